inst_stream_encoder: RTL and testbench

- Encoder/loader for the 9-bit ISA; it is the inverse of the control decoder.
- Accepts symbolic instructions (mnemonic plus operand fields) over a valid/ready handshake.
- Packs each into 9-bit machine code and writes it sequentially into instruction memory, starting at address 0.
- When the last instruction has been written, appends the halt word 9'h1FF (the all-ones Ack pattern).
- Used by the testbench/boot path to load programs without a precompiled hex file.

---
 rtl/inst_stream_encoder_pkg.sv | 43 ++++
 rtl/inst_stream_encoder_pack.sv | 57 +++++
 rtl/inst_stream_encoder.sv | 164 ++++++++++++++++
 tb/tb_inst_stream_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_stream_encoder_pkg.sv
// Shared definitions for the 9-bit ISA program encoder/loader:
// mnemonic enum, error codes, halt word and opcode prefixes.
package inst_stream_encoder_pkg;

  typedef enum logic [4:0] {
    OP_LSL = 5'd0,  OP_LSR = 5'd1,  OP_XOR = 5'd2,  OP_RXR = 5'd3,
    OP_LDR = 5'd4,  OP_STR = 5'd5,  OP_SBS = 5'd6,  OP_DBS = 5'd7,
    OP_JE  = 5'd8,  OP_JNE = 5'd9,  OP_SPC = 5'd10, OP_LUT = 5'd11,
    OP_CTC = 5'd12, OP_CTI = 5'd13, OP_CTS = 5'd14, OP_CBF = 5'd15,
    OP_CPY = 5'd16, OP_ORR = 5'd17, OP_ADD = 5'd18, OP_SUB = 5'd19,
    OP_MOV = 5'd20
  } op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_OVERFLOW = 2'b10,
    ERR_UNKNOWN  = 2'b11
  } err_t;

  localparam logic [8:0] kHALT = 9'h1FF;

  localparam logic [2:0] P_LSL = 3'b000;
  localparam logic [2:0] P_LSR = 3'b001;
  localparam logic [3:0] P_XOR = 4'b0110;
  localparam logic [3:0] P_RXR = 4'b0111;
  localparam logic [4:0] P_LDR = 5'b01000;
  localparam logic [4:0] P_STR = 5'b01001;
  localparam logic [4:0] P_SBS = 5'b01010;
  localparam logic [4:0] P_DBS = 5'b01011;
  localparam logic [3:0] P_JMP = 4'b1000;
  localparam logic [3:0] P_SPC = 4'b1001;
  localparam logic [3:0] P_LUT = 4'b1010;
  localparam logic [5:0] P_CTC = 6'b101100;
  localparam logic [5:0] P_CTI = 6'b101101;
  localparam logic [5:0] P_CTS = 6'b101110;
  localparam logic [8:0] W_CBF = 9'b101111000;
  localparam logic [3:0] P_CPY = 4'b1100;
  localparam logic [3:0] P_ORR = 4'b1101;
  localparam logic [3:0] P_ALU = 4'b1110;
  localparam logic [3:0] P_MOV = 4'b1111;

endpackage

// File: rtl/inst_stream_encoder_pack.sv
// inst_pack: combinational packer from mnemonic + operand fields to a
// 9-bit machine word, with operand-legality and unknown-mnemonic flags.
module inst_pack
  import inst_stream_encoder_pkg::*;
(
  input  logic [4:0] mnem_i,
  input  logic [2:0] fld_a_i,
  input  logic [2:0] fld_b_i,
  input  logic       flag_i,
  input  logic [4:0] imm_i,
  output logic [8:0] word_o,
  output logic       illegal_o,
  output logic       unknown_o
);

  op_t op;
  assign op = op_t'(mnem_i);

  // Encode one instruction; the paired mnemonics (jne, sub) force their flag bit.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    unknown_o = 1'b0;
    case (op)
      OP_LSL: word_o = {P_LSL, fld_a_i, fld_b_i};
      OP_LSR: word_o = {P_LSR, fld_a_i, fld_b_i};
      OP_XOR: word_o = {P_XOR, fld_a_i, 2'b00};
      OP_RXR: word_o = {P_RXR, fld_a_i, 2'b00};
      OP_LDR: word_o = {P_LDR, fld_a_i, 1'b0};
      OP_STR: word_o = {P_STR, fld_a_i, 1'b0};
      OP_SBS: word_o = {P_SBS, fld_a_i, 1'b0};
      OP_DBS: word_o = {P_DBS, fld_a_i, 1'b0};
      OP_JE, OP_JNE: begin
        word_o    = {P_JMP, flag_i | (op == OP_JNE), fld_b_i[1:0], 2'b00};
        illegal_o = (fld_b_i[1:0] == 2'b00);
      end
      OP_SPC: word_o = {P_SPC, fld_b_i[1:0], flag_i, 2'b00};
      OP_LUT: word_o = {P_LUT, fld_a_i, flag_i, 1'b0};
      OP_CTC, OP_CTI, OP_CTS: begin
        if (op == OP_CTC)      word_o = {P_CTC, fld_a_i[1:0], 1'b0};
        else if (op == OP_CTI) word_o = {P_CTI, fld_a_i[1:0], 1'b0};
        else                   word_o = {P_CTS, fld_a_i[1:0], 1'b0};
        illegal_o = (fld_a_i[1:0] == 2'b11);
      end
      OP_CBF: word_o = W_CBF;
      OP_CPY: word_o = {P_CPY, fld_a_i, 2'b00};
      OP_ORR: word_o = {P_ORR, fld_a_i, fld_b_i[1:0]};
      OP_ADD, OP_SUB: word_o = {P_ALU, fld_a_i, flag_i | (op == OP_SUB), 1'b0};
      OP_MOV: begin
        word_o    = {P_MOV, imm_i};
        illegal_o = (imm_i == 5'd31);
      end
      default: unknown_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_stream_encoder.sv
// inst_stream_encoder: accepts symbolic instructions over valid/ready,
// writes packed words sequentially from address 0 and terminates the image
// with the halt word. Optional macro ENCODER_LEGALITY_CHECK_EN enables the
// illegal-operand and overflow checks; without it the address wraps.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// RUN   | accepting instructions
// HALT  | writing the terminating halt word
// DONE  | image complete, waiting for Start
module inst_stream_encoder
  import inst_stream_encoder_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    Mnem,
  input  logic [2:0]    FldA,
  input  logic [2:0]    FldB,
  input  logic          Flag,
  input  logic [4:0]    Imm,
  input  logic          Last,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic [8:0]    WrData,
  output logic          Busy,
  output logic          Done,
  output logic          Error,
  output logic [1:0]    ErrCode,
  output logic [AW:0]   Count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_nxt;
  logic [AW:0]   count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [8:0]    wr_data_q, wr_data_d;
  logic          err_q, err_d;
  err_t          err_code_q, err_code_d;
  err_t          beat_err;

  logic [8:0] word;
  logic       illegal, unknown;

  inst_pack u_pack (
    .mnem_i    (Mnem),
    .fld_a_i   (FldA),
    .fld_b_i   (FldB),
    .flag_i    (Flag),
    .imm_i     (Imm),
    .word_o    (word),
    .illegal_o (illegal),
    .unknown_o (unknown)
  );

  assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  // Classify the presented beat; unknown mnemonic takes priority.
  always_comb begin
    beat_err = ERR_NONE;
    if (unknown) beat_err = ERR_UNKNOWN;
`ifdef ENCODER_LEGALITY_CHECK_EN
    else if (illegal) beat_err = ERR_ILLEGAL;
    else if (addr_q == LAST_ADDR) beat_err = ERR_OVERFLOW;
`endif
  end

`ifndef ENCODER_LEGALITY_CHECK_EN
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

  // Next-state and datapath: a faulty beat skips its write and goes straight to halt.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d    = S_RUN;
          addr_d     = '0;
          count_d    = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      S_RUN: begin
        if (InValid) begin
          if (beat_err != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = beat_err;
            state_d    = S_HALT;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word;
            addr_d    = addr_nxt;
            count_d   = count_q + 1'b1;
            if (Last) state_d = S_HALT;
          end
        end
      end
      S_HALT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = kHALT;
        addr_d    = addr_nxt;
        count_d   = count_q + 1'b1;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any program in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign InReady = (state_q == S_RUN);
  assign Busy    = (state_q == S_RUN) || (state_q == S_HALT);
  assign Done    = (state_q == S_DONE);
  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign Error   = err_q;
  assign ErrCode = err_code_q;
  assign Count   = count_q;

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Scoreboard bench for inst_stream_encoder (AW=4, DEPTH=4). Expected writes
// are queued by the stimulus; a negedge monitor pops and compares each write.
module tb_inst_stream_encoder;
  import inst_stream_encoder_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          InValid = 1'b0;
  logic          InReady;
  logic [4:0]    Mnem = '0;
  logic [2:0]    FldA = '0;
  logic [2:0]    FldB = '0;
  logic          Flag = 1'b0;
  logic [4:0]    Imm = '0;
  logic          Last = 1'b0;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [8:0]    WrData;
  logic          Busy, Done, Error;
  logic [1:0]    ErrCode;
  logic [AW:0]   Count;

  inst_stream_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid), .InReady(InReady),
    .Mnem(Mnem), .FldA(FldA), .FldB(FldB), .Flag(Flag), .Imm(Imm), .Last(Last),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .Done(Done),
    .Error(Error), .ErrCode(ErrCode), .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [AW-1:0] addr; logic [8:0] data; } wr_t;
  wr_t exp_q[$];
  int  wr_cycles[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [8:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  always @(posedge Clk) cyc++;

  // Monitor: every write strobe must match the head of the expectation queue.
  always @(negedge Clk) begin
    if (!Reset && WrEn) begin
      wr_cycles.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(WrAddr), 32'hFFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 32'(WrAddr), 32'(w.addr));
        chk("wr_data", 32'(WrData), 32'(w.data));
      end
    end
  end

  task automatic start_prog();
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    #1;
    chk("start_busy", 32'(Busy), 1);
    chk("start_count", 32'(Count), 0);
    chk("start_error", 32'(Error), 0);
    chk("start_errcode", 32'(ErrCode), 0);
  endtask

  task automatic send(input logic [4:0] m, input logic [2:0] a, input logic [2:0] b,
                      input logic f, input logic [4:0] imm, input logic last);
    int n = 0;
    @(negedge Clk);
    Mnem = m; FldA = a; FldB = b; Flag = f; Imm = imm; Last = last;
    InValid = 1'b1;
    while (!InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) chk("inready_timeout", 32'(InReady), 1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Last = 1'b0;
  endtask

  task automatic wait_done(input int exp_count, input logic exp_err, input logic [1:0] exp_code);
    int n = 0;
    while (!Done && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("done", 32'(Done), 1);
    @(negedge Clk);
    #1;
    chk("done_busy", 32'(Busy), 0);
    chk("done_count", 32'(Count), 32'(exp_count));
    chk("done_error", 32'(Error), 32'(exp_err));
    chk("done_errcode", 32'(ErrCode), 32'(exp_code));
    chk("queue_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_wren", 32'(WrEn), 0);
    chk("rst_inready", 32'(InReady), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_count", 32'(Count), 0);
    chk("rst_wraddr", 32'(WrAddr), 0);
    chk("rst_wrdata", 32'(WrData), 0);
    Reset = 1'b0;

    // lsl A=2,B=3 ; add A=4,Flag=1 (Last)
    start_prog();
    expect_wr(0, 9'h013); expect_wr(1, 9'h1D2); expect_wr(2, 9'h1FF);
    send(OP_LSL, 3'd2, 3'd3, 1'b0, 5'd0, 1'b0);
    send(OP_ADD, 3'd4, 3'd0, 1'b1, 5'd0, 1'b1);
    wait_done(3, 1'b0, 2'b00);

    // jne B=2 ; spc B=3,Flag=1 (Last)
    start_prog();
    expect_wr(0, 9'h118); expect_wr(1, 9'h13C); expect_wr(2, 9'h1FF);
    send(OP_JNE, 3'd0, 3'd2, 1'b1, 5'd0, 1'b0);
    send(OP_SPC, 3'd0, 3'd3, 1'b1, 5'd0, 1'b1);
    wait_done(3, 1'b0, 2'b00);

    // mov #31 (Last)
    start_prog();
`ifdef ENCODER_LEGALITY_CHECK_EN
    expect_wr(0, 9'h1FF);
    send(OP_MOV, 3'd0, 3'd0, 1'b0, 5'd31, 1'b1);
    wait_done(1, 1'b1, 2'b01);
`else
    expect_wr(0, 9'h1FF); expect_wr(1, 9'h1FF);
    send(OP_MOV, 3'd0, 3'd0, 1'b0, 5'd31, 1'b1);
    wait_done(2, 1'b0, 2'b00);
`endif

    // je with pcsel=00 (Last)
    start_prog();
`ifdef ENCODER_LEGALITY_CHECK_EN
    expect_wr(0, 9'h1FF);
    send(OP_JE, 3'd0, 3'd0, 1'b0, 5'd0, 1'b1);
    wait_done(1, 1'b1, 2'b01);
`else
    expect_wr(0, 9'h100); expect_wr(1, 9'h1FF);
    send(OP_JE, 3'd0, 3'd0, 1'b0, 5'd0, 1'b1);
    wait_done(2, 1'b0, 2'b00);
`endif

    // unknown mnemonic
    start_prog();
    expect_wr(0, 9'h1FF);
    send(5'd25, 3'd1, 3'd1, 1'b0, 5'd0, 1'b0);
    wait_done(1, 1'b1, 2'b11);

    // four non-Last instructions into a 4-word memory
    start_prog();
    expect_wr(0, 9'h178); expect_wr(1, 9'h194); expect_wr(2, 9'h1AD);
`ifdef ENCODER_LEGALITY_CHECK_EN
    expect_wr(3, 9'h1FF);
    send(OP_CBF, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_CPY, 3'd5, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_ORR, 3'd3, 3'd1, 1'b0, 5'd0, 1'b0);
    send(OP_CTC, 3'd1, 3'd0, 1'b0, 5'd0, 1'b0);
    wait_done(4, 1'b1, 2'b10);
`else
    expect_wr(3, 9'h162); expect_wr(0, 9'h0DC); expect_wr(1, 9'h1FF);
    send(OP_CBF, 3'd0, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_CPY, 3'd5, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_ORR, 3'd3, 3'd1, 1'b0, 5'd0, 1'b0);
    send(OP_CTC, 3'd1, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_XOR, 3'd7, 3'd0, 1'b0, 5'd0, 1'b1);
    wait_done(6, 1'b0, 2'b00);
`endif

    // back-to-back stream with a stray Start during RUN; Last at DEPTH-2
    start_prog();
    base = wr_cycles.size();
    fork
      begin
        @(negedge Clk); @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
      end
    join_none
    expect_wr(0, 9'h04F); expect_wr(1, 9'h08C); expect_wr(2, 9'h14A); expect_wr(3, 9'h1FF);
    send(OP_LSR, 3'd1, 3'd7, 1'b0, 5'd0, 1'b0);
    send(OP_LDR, 3'd6, 3'd0, 1'b0, 5'd0, 1'b0);
    send(OP_LUT, 3'd2, 3'd0, 1'b1, 5'd0, 1'b1);
    chk("inready_after_last", 32'(InReady), 0);
    wait_done(4, 1'b0, 2'b00);
    chk("stream_writes", 32'(wr_cycles.size() - base), 4);
    for (int i = base + 1; i < wr_cycles.size(); i++)
      chk("stream_gap", 32'(wr_cycles[i] - wr_cycles[i-1]), 1);

    // reset mid-stream, then reload from address 0
    start_prog();
    expect_wr(0, 9'h001);
    send(OP_LSL, 3'd0, 3'd1, 1'b0, 5'd0, 1'b0);
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_inready", 32'(InReady), 0);
    chk("midrst_busy", 32'(Busy), 0);
    chk("midrst_wren", 32'(WrEn), 0);
    chk("midrst_count", 32'(Count), 0);
    chk("midrst_wraddr", 32'(WrAddr), 0);
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_queue", 32'(exp_q.size()), 0);
    start_prog();
    expect_wr(0, 9'h0A2); expect_wr(1, 9'h1FF);
    send(OP_SBS, 3'd1, 3'd0, 1'b0, 5'd0, 1'b1);
    wait_done(2, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
